// File: rtl/decode_stage.sv
// Registered MIPS ID stage: control decode, register file with write-back bypass,
// load-use stall detection and the ID/EX pipeline register with bubble insertion.
module decode_stage #(
  parameter int len   = 32,
  parameter int NREGS = 32,
  parameter int NB    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [len-1:0]  in_pc_jump,
  input  logic [31:0]     in_instruccion,
  input  logic            flush,
  input  logic            RegWrite,
  input  logic [NB-1:0]   write_register,
  input  logic [len-1:0]  write_data,
  output logic            stall,
  output logic            out_valid,
  output logic [len-1:0]  out_pc_jump,
  output logic [len-1:0]  out_reg1,
  output logic [len-1:0]  out_reg2,
  output logic [len-1:0]  out_sign_extend,
  output logic [NB-1:0]   out_rs,
  output logic [NB-1:0]   out_rt,
  output logic [NB-1:0]   out_rd,
  output logic [3:0]      execute_bus,
  output logic [2:0]      memory_bus,
  output logic [1:0]      writeBack_bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [len-1:0] r_regs [NREGS];

  logic [5:0]        w_opcode;
  logic [NB-1:0]     w_rs, w_rt, w_rd;
  logic signed [15:0] w_imm;
  logic [len-1:0]    w_sext;
  logic [len-1:0]    w_reg1, w_reg2;
  logic [3:0]        w_exec;
  logic [2:0]        w_mem;
  logic [1:0]        w_wb;
  logic              w_stall;
  logic              w_bubble;

  logic              r_out_valid;
  logic [len-1:0]    r_pc_jump, r_reg1, r_reg2, r_sext;
  logic [NB-1:0]     r_rs, r_rt, r_rd;
  logic [3:0]        r_exec;
  logic [2:0]        r_mem;
  logic [1:0]        r_wb;

  assign w_opcode = in_instruccion[31:26];
  assign w_rs     = in_instruccion[21 +: NB];
  assign w_rt     = in_instruccion[16 +: NB];
  assign w_rd     = in_instruccion[11 +: NB];
  assign w_imm    = in_instruccion[15:0];
  assign w_sext   = len'(w_imm);

  // Register 0 is hardwired: never written, and reads are forced to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (RegWrite && (write_register != '0)) begin
      r_regs[write_register] <= write_data;
    end
  end

  always_comb begin
    w_reg1 = r_regs[w_rs];
    if (w_rs == '0)
      w_reg1 = '0;
    else if (RegWrite && (write_register == w_rs))
      w_reg1 = write_data;
  end

  always_comb begin
    w_reg2 = r_regs[w_rt];
    if (w_rt == '0)
      w_reg2 = '0;
    else if (RegWrite && (write_register == w_rt))
      w_reg2 = write_data;
  end

  always_comb begin
    w_exec = 4'b0000;
    w_mem  = 3'b000;
    w_wb   = 2'b00;
    case (w_opcode)
      OP_RTYPE: begin w_exec = 4'b1100; w_mem = 3'b000; w_wb = 2'b10; end
      OP_LW:    begin w_exec = 4'b0001; w_mem = 3'b010; w_wb = 2'b11; end
      OP_SW:    begin w_exec = 4'b0001; w_mem = 3'b001; w_wb = 2'b00; end
      OP_BEQ:   begin w_exec = 4'b0010; w_mem = 3'b100; w_wb = 2'b00; end
      OP_ADDI:  begin w_exec = 4'b0001; w_mem = 3'b000; w_wb = 2'b10; end
      default:  begin w_exec = 4'b0000; w_mem = 3'b000; w_wb = 2'b00; end
    endcase
  end

  // A load sitting in ID/EX whose destination feeds the instruction in ID.
  assign w_stall = in_valid & r_out_valid & r_mem[1] & (r_rt != '0) &
                   ((r_rt == w_rs) | (r_rt == w_rt)) & ~flush;
  assign w_bubble = flush | w_stall | ~in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_pc_jump   <= '0;
      r_reg1      <= '0;
      r_reg2      <= '0;
      r_sext      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_exec      <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
    end else if (w_bubble) begin
      // Bubble only kills the control; data fields keep their last contents.
      r_out_valid <= 1'b0;
      r_exec      <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
    end else begin
      r_out_valid <= 1'b1;
      r_pc_jump   <= in_pc_jump;
      r_reg1      <= w_reg1;
      r_reg2      <= w_reg2;
      r_sext      <= w_sext;
      r_rs        <= w_rs;
      r_rt        <= w_rt;
      r_rd        <= w_rd;
      r_exec      <= w_exec;
      r_mem       <= w_mem;
      r_wb        <= w_wb;
    end
  end

  assign stall           = w_stall;
  assign out_valid       = r_out_valid;
  assign out_pc_jump     = r_pc_jump;
  assign out_reg1        = r_reg1;
  assign out_reg2        = r_reg2;
  assign out_sign_extend = r_sext;
  assign out_rs          = r_rs;
  assign out_rt          = r_rt;
  assign out_rd          = r_rd;
  assign execute_bus     = r_exec;
  assign memory_bus      = r_mem;
  assign writeBack_bus   = r_wb;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, bypass, load-use stall, flush and reset.
module tb_decode_stage;

  localparam int len   = 32;
  localparam int NREGS = 32;
  localparam int NB    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [len-1:0]  in_pc_jump;
  logic [31:0]     in_instruccion;
  logic            flush;
  logic            RegWrite;
  logic [NB-1:0]   write_register;
  logic [len-1:0]  write_data;
  logic            stall;
  logic            out_valid;
  logic [len-1:0]  out_pc_jump, out_reg1, out_reg2, out_sign_extend;
  logic [NB-1:0]   out_rs, out_rt, out_rd;
  logic [3:0]      execute_bus;
  logic [2:0]      memory_bus;
  logic [1:0]      writeBack_bus;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.len(len), .NREGS(NREGS), .NB(NB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc_jump(in_pc_jump),
    .in_instruccion(in_instruccion), .flush(flush), .RegWrite(RegWrite),
    .write_register(write_register), .write_data(write_data), .stall(stall),
    .out_valid(out_valid), .out_pc_jump(out_pc_jump), .out_reg1(out_reg1),
    .out_reg2(out_reg2), .out_sign_extend(out_sign_extend), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .execute_bus(execute_bus),
    .memory_bus(memory_bus), .writeBack_bus(writeBack_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid       = 1'b1;
    in_instruccion = instr;
    in_pc_jump     = pc;
  endtask

  task automatic chk_ctrl(input string tag, input logic v, input logic [3:0] ex,
                          input logic [2:0] mem, input logic [1:0] wb);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".exec"},  64'(execute_bus), 64'(ex));
    chk({tag, ".mem"},   64'(memory_bus), 64'(mem));
    chk({tag, ".wb"},    64'(writeBack_bus), 64'(wb));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_ctrl(tag, 1'b0, 4'b0, 3'b0, 2'b0);
    chk({tag, ".pc"},   64'(out_pc_jump), 64'h0);
    chk({tag, ".reg1"}, 64'(out_reg1), 64'h0);
    chk({tag, ".reg2"}, 64'(out_reg2), 64'h0);
    chk({tag, ".sext"}, 64'(out_sign_extend), 64'h0);
    chk({tag, ".idx"},  64'({out_rs, out_rt, out_rd}), 64'h0);
    chk({tag, ".stall"}, 64'(stall), 64'h0);
  endtask

  initial begin
    // Reset with random inputs
    reset          = 1'b1;
    in_valid       = 1'b1;
    in_pc_jump     = $urandom;
    in_instruccion = $urandom;
    flush          = 1'b0;
    RegWrite       = 1'b1;
    write_register = 5'($urandom);
    write_data     = $urandom;
    tick();
    tick();
    chk_all_zero("reset");
    $display("txn reset: outputs cleared");

    reset    = 1'b0;
    RegWrite = 1'b0;
    issue(32'h00A00820, 32'h0000_0010);   // add r1,r5,r0
    tick();
    chk("r5_after_reset.reg1", 64'(out_reg1), 64'h0);
    chk("r5_after_reset.rs",   64'(out_rs), 64'd5);
    chk("r5_after_reset.pc",   64'(out_pc_jump), 64'h10);
    $display("txn read r5 after reset: reg1=%0h", out_reg1);

    // Write r1=7, r2=9 with IF/ID empty
    in_valid = 1'b0;
    RegWrite = 1'b1; write_register = 5'd1; write_data = 32'd7;
    tick();
    chk("empty_slot.valid", 64'(out_valid), 64'h0);
    write_register = 5'd2; write_data = 32'd9;
    tick();
    RegWrite = 1'b0;
    issue(32'h00221820, 32'h0000_0100);   // add r3,r1,r2
    tick();
    chk_ctrl("add", 1'b1, 4'b1100, 3'b000, 2'b10);
    chk("add.reg1", 64'(out_reg1), 64'd7);
    chk("add.reg2", 64'(out_reg2), 64'd9);
    chk("add.rd",   64'(out_rd), 64'd3);
    chk("add.pc",   64'(out_pc_jump), 64'h100);
    chk("add.sext", 64'(out_sign_extend), 64'h1820);
    $display("txn add r3,r1,r2: reg1=%0d reg2=%0d rd=%0d", out_reg1, out_reg2, out_rd);

    // Load-use: lw r4,8(r0) then add r5,r4,r1
    issue(32'h8C040008, 32'h0000_0104);
    tick();
    chk_ctrl("lw", 1'b1, 4'b0001, 3'b010, 2'b11);
    chk("lw.rt",   64'(out_rt), 64'd4);
    chk("lw.sext", 64'(out_sign_extend), 64'h8);
    issue(32'h00812820, 32'h0000_0108);
    #1;
    chk("loaduse.stall", 64'(stall), 64'h1);
    tick();
    chk_ctrl("loaduse.bubble", 1'b0, 4'b0, 3'b0, 2'b0);
    chk("loaduse.hold_rt", 64'(out_rt), 64'd4);
    chk("loaduse.hold_pc", 64'(out_pc_jump), 64'h104);
    chk("loaduse.released", 64'(stall), 64'h0);
    tick();
    chk_ctrl("add_after_stall", 1'b1, 4'b1100, 3'b000, 2'b10);
    chk("add_after_stall.rs",   64'(out_rs), 64'd4);
    chk("add_after_stall.rd",   64'(out_rd), 64'd5);
    chk("add_after_stall.reg2", 64'(out_reg2), 64'd7);
    $display("txn lw/add load-use: one bubble, add issued pc=%0h", out_pc_jump);

    // Same-cycle bypass on r6
    RegWrite = 1'b1; write_register = 5'd6; write_data = 32'hDEADBEEF;
    issue(32'h00C03820, 32'h0000_0200);   // add r7,r6,r0
    tick();
    chk("bypass.reg1", 64'(out_reg1), 64'hDEADBEEF);
    RegWrite = 1'b0;
    issue(32'hACC6FFFC, 32'h0000_0204);   // sw r6,-4(r6)
    tick();
    chk_ctrl("sw", 1'b1, 4'b0001, 3'b001, 2'b00);
    chk("sw.reg1", 64'(out_reg1), 64'hDEADBEEF);
    chk("sw.reg2", 64'(out_reg2), 64'hDEADBEEF);
    chk("sw.sext", 64'(out_sign_extend), 64'hFFFF_FFFC);
    $display("txn bypass r6: reg1=%0h", out_reg1);

    // Register 0 stays zero, addi with negative immediate
    in_valid = 1'b0;
    RegWrite = 1'b1; write_register = 5'd0; write_data = 32'd5;
    tick();
    issue(32'h20088000, 32'h0000_0300);   // addi r8,r0,0x8000 (write r0 still asserted)
    tick();
    RegWrite = 1'b0;
    chk_ctrl("addi", 1'b1, 4'b0001, 3'b000, 2'b10);
    chk("r0.reg1",   64'(out_reg1), 64'h0);
    chk("addi.sext", 64'(out_sign_extend), 64'hFFFF_8000);
    $display("txn addi r8,r0,0x8000: reg1=%0h sext=%0h", out_reg1, out_sign_extend);

    // beq and an unknown opcode
    issue(32'h10220003, 32'h0000_0400);   // beq r1,r2,3
    tick();
    chk_ctrl("beq", 1'b1, 4'b0010, 3'b100, 2'b00);
    chk("beq.reg2", 64'(out_reg2), 64'd9);
    issue(32'h08000010, 32'h0000_0404);   // j: not decoded, NOP controls
    tick();
    chk_ctrl("unknown_op", 1'b1, 4'b0, 3'b0, 2'b0);
    $display("txn beq / unknown opcode decoded");

    // Flush overrides a stall condition
    issue(32'h8C040008, 32'h0000_0500);
    tick();
    issue(32'h00812820, 32'h0000_0504);
    #1;
    chk("flush.pre_stall", 64'(stall), 64'h1);
    flush = 1'b1;
    #1;
    chk("flush.stall", 64'(stall), 64'h0);
    tick();
    flush = 1'b0;
    chk_ctrl("flush.bubble", 1'b0, 4'b0, 3'b0, 2'b0);
    $display("txn flush over stall: bubble inserted");

    // Reset asserted mid-stall
    issue(32'h8C040008, 32'h0000_0600);
    tick();
    issue(32'h00812820, 32'h0000_0604);
    #1;
    chk("midreset.pre_stall", 64'(stall), 64'h1);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    issue(32'h00221820, 32'h0000_0700);   // regs cleared by reset
    tick();
    chk("post_reset.reg1", 64'(out_reg1), 64'h0);
    chk("post_reset.valid", 64'(out_valid), 64'h1);
    $display("txn reset mid-stall: outputs cleared, regs cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered ID stage for the MIPS pipeline: decodes the IF/ID instruction, reads an internal register file with write-back bypass, and holds the ID/EX pipeline register. It adds what the combinational decoder lacks: a valid bit, load-use hazard detection with a stall output to IF, flush/bubble insertion, and configurable datapath width and register count. It sits between the IF/ID register and the execute stage.

## Interface
- `len`, 32, datapath and register width; must be at least 16.
- `NREGS`, 32, number of architectural registers; must be a power of two, at most 32.
- `NB`, `$clog2(NREGS)`, register index width.

- `clk`  in  1  clock; everything updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  the IF/ID slot holds a real instruction.
- `in_pc_jump`  in  len  PC+4 of the instruction.
- `in_instruccion`  in  32  instruction word.
- `flush`  in  1  squash the instruction in ID (branch taken).
- `RegWrite`  in  1  write-back enable.
- `write_register`  in  NB  write-back index.
- `write_data`  in  len  write-back data.
- `stall`  out  1  combinational; IF holds the PC and IF/ID this cycle.
- `out_valid`  out  1  the ID/EX slot holds a real instruction.
- `out_pc_jump`  out  len  registered PC+4.
- `out_reg1`, `out_reg2`  out  len  registered rs and rt operands.
- `out_sign_extend`  out  len  registered sign-extended `imm[15:0]`.
- `out_rs`, `out_rt`, `out_rd`  out  NB  registered `instr[25:21]`, `[20:16]`, `[15:11]`, truncated to NB bits.
- `execute_bus`  out  4  bits: {RegDst, ALUOp[1:0], ALUSrc}.
- `memory_bus`  out  3  bits: {Branch, MemRead, MemWrite}.
- `writeBack_bus`  out  2  bits: {RegWrite, MemtoReg}.

## Operation
- **Control decode** (opcode `instr[31:26]` → exec / mem / wb):
  - R-type `000000` → `1100` / `000` / `10`
  - lw `100011` → `0001` / `010` / `11`
  - sw `101011` → `0001` / `001` / `00`
  - beq `000100` → `0010` / `100` / `00`
  - addi `001000` → `0001` / `000` / `10`
  - any other opcode → all zero (NOP), `out_valid` still follows the rules below.
- **Register file:**
  - NREGS × len.
  - Written on the rising edge when `RegWrite` is high and `write_register` ≠ 0.
  - Register 0 always reads 0.
  - Reset asynchronously clears every entry.
- **Read bypass:** if `RegWrite` is high and `write_register` equals a nonzero read index, that read returns `write_data` in the same cycle.
- **Load-use hazard:**
  - `stall` = `in_valid` & `out_valid` & `memory_bus[1]` & `out_rt` ≠ 0 & (`out_rt` == rs or `out_rt` == rt) & ~`flush`.
- **ID/EX update**, on each rising edge, in priority order:
  1. `flush`, `stall` or ~`in_valid` → bubble: `out_valid`, `execute_bus`, `memory_bus` and `writeBack_bus` become 0; data and index fields hold their previous value.
  2. Otherwise, every output field loads from the current decode and `out_valid` becomes 1.
- A stall lasts exactly one cycle: the bubble clears `out_valid`, which releases it.

## Timing
- Latency is 1 cycle from IF/ID to ID/EX.
- Write-back to a register appears in the read data in the same cycle, through the bypass.
- Reset clears every registered output to 0, including `out_valid`, `out_pc_jump`, the operands, the indices and all three control buses.
- `stall` evaluates to 0 during reset.
- Reset asserted mid-stall: the outputs clear immediately and `stall` drops, because `out_valid` becomes 0.
- `flush` and a stall condition in the same cycle: `flush` wins, `stall` = 0, and a bubble is inserted.
- Simultaneous write-back and read of the same register: the read returns the new value.

## Test plan
- **Reset:** assert `reset` with random inputs → every output is 0 and `stall` = 0; after release, reading r5 returns 0.
- **R-type decode with bypass:** write r1 = 7 and r2 = 9, then issue `add r3,r1,r2` (0x00221820) → next edge: `out_reg1` = 7, `out_reg2` = 9, `out_rd` = 3, `execute_bus` = 1100, `writeBack_bus` = 10, `out_valid` = 1.
- **Load-use:** `lw r4,8(r0)` followed by `add r5,r4,r1` → `stall` = 1 for exactly one cycle; ID/EX shows a bubble (`out_valid` = 0, buses 0); the add issues on the following edge.
- **Same-cycle bypass:** `RegWrite` = 1, `write_register` = 6, `write_data` = 0xDEADBEEF, while decoding rs = 6 → `out_reg1` = 0xDEADBEEF.
- **Register 0:** write r0 = 5, then read r0 → 0. Sign extension: `imm` = 0x8000 → `out_sign_extend` = 0xFFFF8000.
- **Flush over stall:** stall condition plus `flush` = 1 → `stall` = 0 and the next `out_valid` = 0.
- **Reset mid-operation:** assert `reset` mid-stream → all outputs clear immediately.
